filter_frame_writer: RTL and testbench
======================================

Name: filter_frame_writer

Overview:
- Sink end of the sharpening pipeline. Takes the kernel's signed per-pixel result stream, which covers interior pixels only, and clamps each result to WIDTH bits.
- Writes each clamped pixel into an output frame RAM at its true (row+1, col+1) position.
- After the interior is complete, fills the one-pixel border with BORDER_VAL and pulses frame_done.
- This is the writer counterpart to the line-buffer/window reader on the input side.

Parameters:
- WIDTH, 8, output pixel width.
- IN_WIDTH, 12, width of the signed (two's complement) kernel result.
- ROWS, 512, frame height; minimum 3.
- COLS, 512, frame width; minimum 3.
- ADDR_BITS, 18, frame RAM address width; must satisfy 2^ADDR_BITS >= ROWS*COLS.
- BORDER_VAL, 0, WIDTH-bit value written to border pixels.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, arm pulse for one frame; sampled only in IDLE.
- data_in, input, IN_WIDTH, signed kernel result.
- data_in_valid, input, 1, data_in qualifier; one pixel per high cycle.
- wr_en, output, 1, frame RAM write strobe.
- wr_addr, output, ADDR_BITS, frame RAM write address = row*COLS+col.
- wr_data, output, WIDTH, frame RAM write data.
- busy, output, 1, high from the cycle after start is accepted until frame_done.
- frame_done, output, 1, single-cycle pulse at frame completion.
- overflow_err, output, 1, sticky error: input arrived outside INTERIOR.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high.
- On reset: state=IDLE; all counters 0; wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, overflow_err=0. Reset mid-frame abandons the frame immediately; no further writes occur.
- FSM states: IDLE, INTERIOR, BORDER, DONE.
- IDLE:
  - start=1 -> INTERIOR. Clear row/col counters and overflow_err.
  - data_in_valid in IDLE: data dropped, overflow_err set.
- INTERIOR:
  - Each data_in_valid accepts one pixel.
  - Clamp: data_in<0 -> 0; data_in>2^WIDTH-1 -> 2^WIDTH-1; otherwise the low WIDTH bits.
  - Latency is 1: wr_en/wr_addr/wr_data are registered and appear the cycle after the accepting edge.
  - wr_addr=(r+1)*COLS+(c+1), with r in 0..ROWS-3 and c in 0..COLS-3.
  - Address generation uses a running row base incremented by COLS. No multiplier.
  - c wraps from COLS-3 to 0 and r increments on wrap.
  - Accepting pixel r=ROWS-3, c=COLS-3 -> BORDER.
  - Cycles without valid input produce wr_en=0.
- BORDER:
  - Issues one write of BORDER_VAL per cycle, with no stalls.
  - Order: top row addresses 0..COLS-1; then bottom row (ROWS-1)*COLS..ROWS*COLS-1; then for r=1..ROWS-2, r*COLS followed by r*COLS+COLS-1.
  - Total border writes = 2*COLS + 2*(ROWS-2).
  - The last interior write appears on the port in the first BORDER cycle; the first border write appears in the next cycle. There is never more than one write per cycle.
  - After issuing the final border write -> DONE.
  - data_in_valid during BORDER or DONE: data dropped, overflow_err set (sticky).
- DONE:
  - Occupies the cycle after the final border write appears on the port.
  - frame_done=1 and busy=0 in this cycle; state -> IDLE.
- start while not in IDLE is ignored.
- start and data_in_valid together in IDLE: start is accepted, data is dropped, overflow_err is set. The clear of overflow_err by start is overridden by the set.
- wr_addr and wr_data hold their last values when wr_en=0.

Test Plan (ROWS=COLS=6 unless stated; 16 interior pixels, 20 border writes):
- Reset, pulse start, feed 16 consecutive valid pixels of value 10 -> first write addr 7 data 10 one cycle after the first input; interior addrs 7,8,9,10,13,...,28 in order; then 20 writes of 0 in the specified order (0..5, 30..35, 6,11,12,17,18,23,24,29); frame_done exactly one cycle after the addr-29 write; busy low thereafter.
- Clamp: inputs -5, 300, 255, 0, 2047, -2048 -> wr_data 0, 255, 255, 0, 255, 0.
- Gapped input (valid every third cycle) -> same address/data sequence as the back-to-back case, with wr_en=0 in the gap cycles; border phase is unchanged.
- Extra valid input after the 16th pixel (arriving during BORDER) -> data dropped, overflow_err=1 and held through frame_done; next start clears it to 0.
- Reset asserted after the 8th pixel -> next cycle wr_en=0, busy=0, state IDLE; a new start plus 16 pixels produces a clean frame starting at addr 7.
- ROWS=3, COLS=3: one pixel value 100 -> write addr 4 data 100, then border writes 0,1,2,6,7,8,3,5, then frame_done.

Source files
------------

// File: rtl/filter_frame_writer_if.sv
// Bus bundle for filter_frame_writer.
//   data_in / data_in_valid : signed kernel result stream into the writer
//   wr_en / wr_addr / wr_data: frame RAM write port out of the writer
// slave  = writer side, master = producer / RAM side.
interface filter_frame_writer_if #(
  parameter int WIDTH     = 8,
  parameter int IN_WIDTH  = 12,
  parameter int ADDR_BITS = 18
);
  logic [IN_WIDTH-1:0]  data_in;
  logic                 data_in_valid;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [WIDTH-1:0]     wr_data;

  modport slave (
    input  data_in, data_in_valid,
    output wr_en, wr_addr, wr_data
  );

  modport master (
    output data_in, data_in_valid,
    input  wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/filter_frame_writer.sv
// Sink end of the sharpening pipeline. Clamps each signed interior result to
// WIDTH bits and writes it at (row+1, col+1) of the output frame, then fills
// the one-pixel border with BORDER_VAL and pulses frame_done.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   start         : arms one frame (IDLE only)
//   bus (slave)   : data_in/data_in_valid in, wr_en/wr_addr/wr_data out
//   busy          : frame in progress (INTERIOR/BORDER)
//   frame_done    : one-cycle completion pulse
//   overflow_err  : sticky, input seen outside INTERIOR
module filter_frame_writer #(
  parameter int                WIDTH      = 8,
  parameter int                IN_WIDTH   = 12,
  parameter int                ROWS       = 512,
  parameter int                COLS       = 512,
  parameter int                ADDR_BITS  = 18,
  parameter logic [WIDTH-1:0]  BORDER_VAL = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  filter_frame_writer_if.slave   bus,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overflow_err
);
  typedef enum logic [1:0] {IDLE, INTERIOR, BORDER, DONE} state_e;
  typedef enum logic [1:0] {B_TOP, B_BOT, B_SIDE} bphase_e;

  localparam logic [ADDR_BITS-1:0] C_LAST    = ADDR_BITS'(COLS - 3);
  localparam logic [ADDR_BITS-1:0] R_LAST    = ADDR_BITS'(ROWS - 3);
  localparam logic [ADDR_BITS-1:0] COLS_A    = ADDR_BITS'(COLS);
  localparam logic [ADDR_BITS-1:0] FIRST_PIX = ADDR_BITS'(COLS + 1);
  localparam logic [ADDR_BITS-1:0] TOP_LAST  = ADDR_BITS'(COLS - 1);
  localparam logic [ADDR_BITS-1:0] BOT_FIRST = ADDR_BITS'((ROWS - 1) * COLS);
  localparam logic [ADDR_BITS-1:0] BOT_LAST  = ADDR_BITS'(ROWS * COLS - 1);
  localparam logic [ADDR_BITS-1:0] SIDE_LAST = ADDR_BITS'((ROWS - 1) * COLS - 1);

  state_e               state_q, state_d;
  bphase_e              bph_q, bph_d;
  logic [ADDR_BITS-1:0] row_q, row_d, col_q, col_d;
  logic [ADDR_BITS-1:0] pix_base_q, pix_base_d;   // (row+1)*COLS+1
  logic [ADDR_BITS-1:0] bd_addr_q, bd_addr_d;
  logic                 side_right_q, side_right_d;
  logic                 bend_q, bend_d;            // last border write issued
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]     wr_data_q, wr_data_d;
  logic                 err_q, err_d;
  logic [WIDTH-1:0]     clamped;

  // Negative -> 0, any set bit above WIDTH -> all ones, else low bits.
  always_comb begin
    if (bus.data_in[IN_WIDTH-1])                 clamped = '0;
    else if (|bus.data_in[IN_WIDTH-2:WIDTH])     clamped = '1;
    else                                         clamped = bus.data_in[WIDTH-1:0];
  end

  always_comb begin
    state_d      = state_q;
    bph_d        = bph_q;
    row_d        = row_q;
    col_d        = col_q;
    pix_base_d   = pix_base_q;
    bd_addr_d    = bd_addr_q;
    side_right_d = side_right_q;
    bend_d       = bend_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = INTERIOR;
          row_d      = '0;
          col_d      = '0;
          pix_base_d = FIRST_PIX;
          err_d      = 1'b0;
        end
        // set wins over the start clear
        if (bus.data_in_valid) err_d = 1'b1;
      end
      INTERIOR: begin
        if (bus.data_in_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = pix_base_q + col_q;
          wr_data_d = clamped;
          if (col_q == C_LAST) begin
            col_d      = '0;
            row_d      = row_q + 1'b1;
            pix_base_d = pix_base_q + COLS_A;
            if (row_q == R_LAST) begin
              state_d      = BORDER;
              bph_d        = B_TOP;
              bd_addr_d    = '0;
              side_right_d = 1'b0;
              bend_d       = 1'b0;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      BORDER: begin
        if (bus.data_in_valid) err_d = 1'b1;
        // One drain cycle after the last issue so DONE follows its appearance.
        if (bend_q) begin
          state_d = DONE;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = bd_addr_q;
          wr_data_d = BORDER_VAL;
          case (bph_q)
            B_TOP: begin
              if (bd_addr_q == TOP_LAST) begin
                bd_addr_d = BOT_FIRST;
                bph_d     = B_BOT;
              end else bd_addr_d = bd_addr_q + 1'b1;
            end
            B_BOT: begin
              if (bd_addr_q == BOT_LAST) begin
                bd_addr_d    = COLS_A;
                bph_d        = B_SIDE;
                side_right_d = 1'b0;
              end else bd_addr_d = bd_addr_q + 1'b1;
            end
            default: begin
              // left edge r*COLS, then right edge r*COLS+COLS-1
              if (!side_right_q) begin
                bd_addr_d    = bd_addr_q + (COLS_A - 1'b1);
                side_right_d = 1'b1;
              end else if (bd_addr_q == SIDE_LAST) begin
                bend_d = 1'b1;
              end else begin
                bd_addr_d    = bd_addr_q + 1'b1;
                side_right_d = 1'b0;
              end
            end
          endcase
        end
      end
      default: begin
        if (bus.data_in_valid) err_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bph_q        <= B_TOP;
      row_q        <= '0;
      col_q        <= '0;
      pix_base_q   <= '0;
      bd_addr_q    <= '0;
      side_right_q <= 1'b0;
      bend_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bph_q        <= bph_d;
      row_q        <= row_d;
      col_q        <= col_d;
      pix_base_q   <= pix_base_d;
      bd_addr_q    <= bd_addr_d;
      side_right_q <= side_right_d;
      bend_q       <= bend_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      err_q        <= err_d;
    end
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = (state_q == INTERIOR) || (state_q == BORDER);
  assign frame_done   = (state_q == DONE);
  assign overflow_err = err_q;
endmodule

// File: tb/tb_filter_frame_writer.sv
// Directed bench: 6x6 frame writer (main) plus a 3x3 instance (minimum size).
module tb_filter_frame_writer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, busy, frame_done, overflow_err;
  logic reset3, start3, busy3, done3, ovf3;

  filter_frame_writer_if #(.WIDTH(8), .IN_WIDTH(12), .ADDR_BITS(18)) bus ();
  filter_frame_writer_if #(.WIDTH(8), .IN_WIDTH(12), .ADDR_BITS(4))  bus3 ();

  filter_frame_writer #(.WIDTH(8), .IN_WIDTH(12), .ROWS(6), .COLS(6),
                        .ADDR_BITS(18), .BORDER_VAL(8'd0)) u_dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .frame_done(frame_done), .overflow_err(overflow_err));

  filter_frame_writer #(.WIDTH(8), .IN_WIDTH(12), .ROWS(3), .COLS(3),
                        .ADDR_BITS(4), .BORDER_VAL(8'd0)) u_dut3 (
    .clk(clk), .reset(reset3), .start(start3), .bus(bus3),
    .busy(busy3), .frame_done(done3), .overflow_err(ovf3));

  int total = 0;
  int bad   = 0;

  int border6[20] = '{0,1,2,3,4,5,30,31,32,33,34,35,6,11,12,17,18,23,24,29};
  int border3[8]  = '{0,1,2,6,7,8,3,5};
  int cin[16]     = '{-5,300,255,0,2047,-2048,10,10,10,10,10,10,10,10,10,10};
  int cexp[16]    = '{0,255,255,0,255,0,10,10,10,10,10,10,10,10,10,10};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int int_addr(input int i);
    return (i / 4 + 1) * 6 + (i % 4) + 1;
  endfunction

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", {31'd0, busy}, 1);
  endtask

  task automatic feed(input int i, input bit clampset);
    bus.data_in       = clampset ? 12'(cin[i]) : 12'd10;
    bus.data_in_valid = 1'b1;
    step();
    bus.data_in_valid = 1'b0;
    chk("int_en",   {31'd0, bus.wr_en}, 1);
    chk("int_addr", {14'd0, bus.wr_addr}, int_addr(i));
    chk("int_data", {24'd0, bus.wr_data}, clampset ? cexp[i] : 10);
  endtask

  // Frame already started; feeds 16 pixels and checks border + completion.
  task automatic run_frame(input int gap, input bit clampset, input bit extra,
                           input bit exp_ovf);
    for (int i = 0; i < 16; i++) begin
      feed(i, clampset);
      if (i < 15)
        for (int g = 0; g < gap; g++) begin
          step();
          chk("gap_en",   {31'd0, bus.wr_en}, 0);
          chk("gap_hold", {14'd0, bus.wr_addr}, int_addr(i));
        end
    end
    if (extra) begin
      bus.data_in       = 12'd77;
      bus.data_in_valid = 1'b1;
    end
    for (int k = 0; k < 20; k++) begin
      step();
      bus.data_in_valid = 1'b0;
      chk("bd_en",   {31'd0, bus.wr_en}, 1);
      chk("bd_addr", {14'd0, bus.wr_addr}, border6[k]);
      chk("bd_data", {24'd0, bus.wr_data}, 0);
    end
    chk("last_busy", {31'd0, busy}, 1);
    chk("last_done", {31'd0, frame_done}, 0);
    step();
    chk("done",      {31'd0, frame_done}, 1);
    chk("done_busy", {31'd0, busy}, 0);
    chk("done_en",   {31'd0, bus.wr_en}, 0);
    chk("done_ovf",  {31'd0, overflow_err}, {31'd0, exp_ovf});
    step();
    chk("post_done", {31'd0, frame_done}, 0);
    chk("post_busy", {31'd0, busy}, 0);
    chk("post_hold", {14'd0, bus.wr_addr}, 29);
    chk("post_ovf",  {31'd0, overflow_err}, {31'd0, exp_ovf});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    reset3 = 1'b1; start3 = 1'b0;
    bus.data_in = '0;  bus.data_in_valid = 1'b0;
    bus3.data_in = '0; bus3.data_in_valid = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_en",   {31'd0, bus.wr_en}, 0);
    chk("rst_addr", {14'd0, bus.wr_addr}, 0);
    chk("rst_data", {24'd0, bus.wr_data}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, frame_done}, 0);
    chk("rst_ovf",  {31'd0, overflow_err}, 0);
    step();

    // back-to-back, constant 10
    do_start();
    run_frame(0, 1'b0, 1'b0, 1'b0);
    // clamp values
    do_start();
    run_frame(0, 1'b1, 1'b0, 1'b0);
    // gapped input with a stray pixel during BORDER
    do_start();
    run_frame(2, 1'b0, 1'b1, 1'b1);

    // next start clears overflow; abandon after 8 pixels
    do_start();
    chk("start_clr_ovf", {31'd0, overflow_err}, 0);
    for (int i = 0; i < 8; i++) feed(i, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_en",   {31'd0, bus.wr_en}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    step();
    chk("idle_no_wr", {31'd0, bus.wr_en}, 0);

    // stray input in IDLE, then start and valid together
    bus.data_in_valid = 1'b1;
    step();
    chk("idle_ovf",  {31'd0, overflow_err}, 1);
    chk("idle_busy", {31'd0, busy}, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    bus.data_in_valid = 1'b0;
    chk("sv_ovf",  {31'd0, overflow_err}, 1);
    chk("sv_busy", {31'd0, busy}, 1);
    chk("sv_en",   {31'd0, bus.wr_en}, 0);
    run_frame(0, 1'b0, 1'b0, 1'b1);

    // minimum 3x3 frame
    reset3 = 1'b0;
    step();
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    chk("s3_busy", {31'd0, busy3}, 1);
    bus3.data_in = 12'd100;
    bus3.data_in_valid = 1'b1;
    step();
    bus3.data_in_valid = 1'b0;
    chk("s3_en",   {31'd0, bus3.wr_en}, 1);
    chk("s3_addr", {28'd0, bus3.wr_addr}, 4);
    chk("s3_data", {24'd0, bus3.wr_data}, 100);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("s3_bd_en",   {31'd0, bus3.wr_en}, 1);
      chk("s3_bd_addr", {28'd0, bus3.wr_addr}, border3[k]);
      chk("s3_bd_data", {24'd0, bus3.wr_data}, 0);
    end
    chk("s3_pre_done", {31'd0, done3}, 0);
    step();
    chk("s3_done", {31'd0, done3}, 1);
    chk("s3_ovf",  {31'd0, ovf3}, 0);
    step();
    chk("s3_idle", {31'd0, busy3}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
